// File: rtl/time_offset_calc.sv
// rtl/time_offset_calc.sv - clock offset = t_master + path_delay - t_local, mixed radix in/out
module time_offset_calc #(
    parameter logic [47:0] P_OFFSET_LIMIT = 48'd125000000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [47:0] iv_master_time,
    input  logic [47:0] iv_local_rx_time,
    input  logic [31:0] iv_path_delay,
    input  logic        i_sample_valid,
    output logic [48:0] ov_time_offset,
    output logic        o_time_offset_wr,
    output logic        o_busy,
    output logic [15:0] ov_drop_cnt,
    output logic [15:0] ov_reject_cnt
);

    typedef enum logic [2:0] {IDLE, LIN, SUB, DIV, OUT} state_t;

    state_t      state;
    logic [47:0] master_q;
    logic [47:0] local_q;
    logic [31:0] delay_q;
    logic [47:0] lin_master;
    logic [47:0] lin_local;
    logic        sign_q;
    logic [48:0] div_q;
    logic [6:0]  rem_q;
    logic [5:0]  step;

    function automatic logic [47:0] lin(input logic [47:0] t);
        logic [47:0] x;
        x = {7'd0, t[47:7]};
        return (x << 7) - (x << 2) + x + {41'd0, t[6:0]};
    endfunction

    logic [49:0] diff;
    logic [48:0] mag;
    logic        over_limit;
    assign diff       = {2'b00, lin_master} + {18'd0, delay_q} - {2'b00, lin_local};
    assign mag        = diff[49] ? 49'(-diff) : diff[48:0];
    assign over_limit = mag > {1'b0, P_OFFSET_LIMIT};

    // div_q shifts the dividend out at the top while quotient bits enter at the bottom
    logic [7:0]  trial;
    logic        qbit;
    logic [6:0]  rem_next;
    logic [48:0] div_next;
    assign trial    = {rem_q, div_q[48]};
    assign qbit     = trial >= 8'd125;
    assign rem_next = qbit ? 7'(trial - 8'd125) : trial[6:0];
    assign div_next = {div_q[47:0], qbit};

    logic bad_cycle;
    assign bad_cycle = (master_q[6:0] > 7'd124) || (local_q[6:0] > 7'd124);

    assign o_busy = (state != IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state            <= IDLE;
            master_q         <= '0;
            local_q          <= '0;
            delay_q          <= '0;
            lin_master       <= '0;
            lin_local        <= '0;
            sign_q           <= 1'b0;
            div_q            <= '0;
            rem_q            <= '0;
            step             <= '0;
            ov_time_offset   <= '0;
            o_time_offset_wr <= 1'b0;
            ov_drop_cnt      <= '0;
            ov_reject_cnt    <= '0;
        end else begin
            o_time_offset_wr <= 1'b0;
            if (i_sample_valid && state != IDLE && ov_drop_cnt != 16'hFFFF)
                ov_drop_cnt <= ov_drop_cnt + 16'd1;

            case (state)
                IDLE: begin
                    if (i_sample_valid) begin
                        master_q <= iv_master_time;
                        local_q  <= iv_local_rx_time;
                        delay_q  <= iv_path_delay;
                        state    <= LIN;
                    end
                end
                LIN: begin
                    lin_master <= lin(master_q);
                    lin_local  <= lin(local_q);
                    if (bad_cycle) begin
                        if (ov_reject_cnt != 16'hFFFF) ov_reject_cnt <= ov_reject_cnt + 16'd1;
                        state <= IDLE;
                    end else begin
                        state <= SUB;
                    end
                end
                SUB: begin
                    sign_q <= diff[49];
                    div_q  <= mag;
                    rem_q  <= '0;
                    step   <= '0;
                    if (over_limit) begin
                        if (ov_reject_cnt != 16'hFFFF) ov_reject_cnt <= ov_reject_cnt + 16'd1;
                        state <= IDLE;
                    end else begin
                        state <= DIV;
                    end
                end
                DIV: begin
                    div_q <= div_next;
                    rem_q <= rem_next;
                    step  <= step + 6'd1;
                    if (step == 6'd48) begin
                        ov_time_offset   <= {sign_q, div_next[40:0], rem_next};
                        o_time_offset_wr <= 1'b1;
                        state            <= OUT;
                    end
                end
                OUT: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
